// File: rtl/pc_sequencer.sv
// Registered program counter: sequential step, absolute jump, PC-relative branch and stall.
// Raises a sticky flag on address wrap-around and a one-cycle pulse when a jump target is misaligned.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
    parameter int unsigned      OFFSET_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    jump,
    input  logic [WIDTH-1:0]        jump_addr,
    input  logic                    branch,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    output logic [WIDTH-1:0]        pc,
    output logic [WIDTH-1:0]        pc_seq,
    output logic                    overflow,
    output logic                    misaligned
);
    localparam int unsigned      EXT_W  = WIDTH + OFFSET_WIDTH + 2;
    localparam int unsigned      SHIFT  = $clog2(STEP);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pc_d, pc_q;
    logic             overflow_d, overflow_q;
    logic             misaligned_d, misaligned_q;
    logic [WIDTH:0]   seq_sum_s;
    logic [EXT_W-1:0] pc_ext_s, offset_ext_s, branch_sum_s;
    logic             jump_misaligned_s, branch_wrap_s;

    // Branch target is formed at a width where it can never silently wrap, so any
    // nonzero bit above WIDTH (including the sign) means the exact target left the address space.
    assign seq_sum_s         = {1'b0, pc_q} + {1'b0, STEP_W};
    assign pc_ext_s          = {{(OFFSET_WIDTH + 2){1'b0}}, pc_q};
    assign offset_ext_s      = {{(EXT_W - OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset} << SHIFT;
    assign branch_sum_s      = pc_ext_s + EXT_W'(STEP) + offset_ext_s;
    assign branch_wrap_s     = branch_sum_s[EXT_W-1:WIDTH] != {(EXT_W - WIDTH){1'b0}};
    assign jump_misaligned_s = (jump_addr & ALIGN_MASK) != {WIDTH{1'b0}};

    // Next-state selection: stall > jump > branch > sequential
    always_comb begin
        pc_d         = pc_q;
        overflow_d   = overflow_q;
        misaligned_d = 1'b0;
        if (stall) begin
            pc_d       = pc_q;
            overflow_d = overflow_q;
        end else if (jump) begin
            if (jump_misaligned_s) begin
                misaligned_d = 1'b1;
            end else begin
                pc_d       = jump_addr;
                overflow_d = 1'b0;
            end
        end else if (branch) begin
            pc_d       = branch_sum_s[WIDTH-1:0];
            overflow_d = overflow_q | branch_wrap_s;
        end else begin
            pc_d       = seq_sum_s[WIDTH-1:0];
            overflow_d = overflow_q | seq_sum_s[WIDTH];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            overflow_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            overflow_q   <= overflow_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc         = pc_q;
    assign pc_seq     = seq_sum_s[WIDTH-1:0];
    assign overflow   = overflow_q;
    assign misaligned = misaligned_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default 32-bit instance plus an 8-bit, step-2 instance.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        reset_a = 1'b1, stall_a = 1'b0, jump_a = 1'b0, branch_a = 1'b0;
    logic [31:0] jump_addr_a = 32'h0;
    logic [15:0] offset_a = 16'h0;
    logic [31:0] pc_a, pc_seq_a;
    logic        ovf_a, mis_a;

    logic        reset_b = 1'b1, stall_b = 1'b0, jump_b = 1'b0, branch_b = 1'b0;
    logic [7:0]  jump_addr_b = 8'h0;
    logic [7:0]  offset_b = 8'h0;
    logic [7:0]  pc_b, pc_seq_b;
    logic        ovf_b, mis_b;

    pc_sequencer dut_a (
        .clk(clk), .reset(reset_a), .stall(stall_a), .jump(jump_a), .jump_addr(jump_addr_a),
        .branch(branch_a), .branch_offset(offset_a), .pc(pc_a), .pc_seq(pc_seq_a),
        .overflow(ovf_a), .misaligned(mis_a)
    );

    pc_sequencer #(.WIDTH(8), .STEP(2), .RESET_VECTOR(8'h10), .OFFSET_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset_b), .stall(stall_b), .jump(jump_b), .jump_addr(jump_addr_b),
        .branch(branch_b), .branch_offset(offset_b), .pc(pc_b), .pc_seq(pc_seq_b),
        .overflow(ovf_b), .misaligned(mis_b)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        reset_a = 1'b0; stall_a = 1'b0; jump_a = 1'b0; branch_a = 1'b0;
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        cyc();
        checks++;
        if (pc_a !== 32'h0 || pc_seq_a !== 32'h4 || ovf_a !== 1'b0 || mis_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h seq=%h ovf=%b mis=%b, want pc=0 seq=4 ovf=0 mis=0", pc_a, pc_seq_a, ovf_a, mis_a);
        end
        idle_a();
        for (int i = 1; i <= 3; i++) begin
            cyc();
            checks++;
            if (pc_a !== 32'(4 * i) || ovf_a !== 1'b0) begin
                errors++;
                $display("FAIL free_run_%0d: pc=%h ovf=%b, want pc=%h ovf=0", i, pc_a, ovf_a, 32'(4 * i));
            end
        end
        checks++;
        if (pc_seq_a !== 32'd16) begin
            errors++;
            $display("FAIL pc_seq_follow: got %h, want 10", pc_seq_a);
        end
    endtask

    task automatic test_seq_stall();
        jump_a = 1'b1; jump_addr_a = 32'd180;
        cyc();
        jump_a = 1'b0;
        cyc();
        checks++;
        if (pc_a !== 32'd184) begin
            errors++;
            $display("FAIL seq_after_jump: pc=%0d, want 184", pc_a);
        end
        stall_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (pc_a !== 32'd184) begin
                errors++;
                $display("FAIL stall_hold_%0d: pc=%0d, want 184", i, pc_a);
            end
        end
        // stall beats jump, including a misaligned one (no pulse)
        jump_a = 1'b1; jump_addr_a = 32'h300;
        cyc();
        jump_addr_a = 32'h301;
        cyc();
        checks++;
        if (pc_a !== 32'd184 || mis_a !== 1'b0) begin
            errors++;
            $display("FAIL stall_over_jump: pc=%h mis=%b, want pc=b8 mis=0", pc_a, mis_a);
        end
        idle_a();
    endtask

    task automatic test_branch();
        jump_a = 1'b1; jump_addr_a = 32'h100;
        cyc();
        checks++;
        if (pc_a !== 32'h100) begin
            errors++;
            $display("FAIL jump_aligned: pc=%h, want 100", pc_a);
        end
        jump_a = 1'b0; branch_a = 1'b1; offset_a = 16'hFFFE;
        cyc();
        checks++;
        if (pc_a !== 32'hFC || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL branch_back: pc=%h ovf=%b, want pc=fc ovf=0", pc_a, ovf_a);
        end
        offset_a = 16'd3;
        cyc();
        checks++;
        if (pc_a !== 32'h10C || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL branch_fwd: pc=%h ovf=%b, want pc=10c ovf=0", pc_a, ovf_a);
        end
        idle_a();
    endtask

    task automatic test_wrap();
        jump_a = 1'b1; jump_addr_a = 32'hFFFF_FFF8;
        cyc();
        jump_a = 1'b0;
        cyc();
        checks++;
        if (pc_a !== 32'hFFFF_FFFC || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL pre_wrap: pc=%h ovf=%b, want pc=fffffffc ovf=0", pc_a, ovf_a);
        end
        cyc();
        checks++;
        if (pc_a !== 32'h0 || ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL wrap: pc=%h ovf=%b, want pc=0 ovf=1", pc_a, ovf_a);
        end
        cyc();
        checks++;
        if (pc_a !== 32'h4 || ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: pc=%h ovf=%b, want pc=4 ovf=1", pc_a, ovf_a);
        end
        jump_a = 1'b1; jump_addr_a = 32'h40;
        cyc();
        checks++;
        if (pc_a !== 32'h40 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL jump_clears_ovf: pc=%h ovf=%b, want pc=40 ovf=0", pc_a, ovf_a);
        end
        idle_a();
    endtask

    task automatic test_misaligned();
        // pc = 0x40 here; rejected jump also suppresses the same-cycle branch
        jump_a = 1'b1; jump_addr_a = 32'h102; branch_a = 1'b1; offset_a = 16'd5;
        cyc();
        checks++;
        if (pc_a !== 32'h40 || mis_a !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_reject: pc=%h mis=%b, want pc=40 mis=1", pc_a, mis_a);
        end
        idle_a();
        cyc();
        checks++;
        if (pc_a !== 32'h44 || mis_a !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_pulse_end: pc=%h mis=%b, want pc=44 mis=0", pc_a, mis_a);
        end
        jump_a = 1'b1; jump_addr_a = 32'h103;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (pc_a !== 32'h44 || mis_a !== 1'b1) begin
                errors++;
                $display("FAIL misaligned_b2b_%0d: pc=%h mis=%b, want pc=44 mis=1", i, pc_a, mis_a);
            end
        end
        idle_a();
        cyc();
        checks++;
        if (pc_a !== 32'h48 || mis_a !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_b2b_end: pc=%h mis=%b, want pc=48 mis=0", pc_a, mis_a);
        end
    endtask

    task automatic test_branch_overflow();
        jump_a = 1'b1; jump_addr_a = 32'hFFFF_FFF0;
        cyc();
        jump_a = 1'b0; branch_a = 1'b1; offset_a = 16'd4;
        cyc();
        checks++;
        if (pc_a !== 32'h4 || ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL branch_wrap_up: pc=%h ovf=%b, want pc=4 ovf=1", pc_a, ovf_a);
        end
        branch_a = 1'b0; jump_a = 1'b1; jump_addr_a = 32'h8;
        cyc();
        jump_a = 1'b0; branch_a = 1'b1; offset_a = 16'hFFFC;
        cyc();
        checks++;
        if (pc_a !== 32'hFFFF_FFFC || ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL branch_wrap_down: pc=%h ovf=%b, want pc=fffffffc ovf=1", pc_a, ovf_a);
        end
        // reset wins over a same-cycle jump
        branch_a = 1'b0; reset_a = 1'b1; jump_a = 1'b1; jump_addr_a = 32'h200;
        cyc();
        checks++;
        if (pc_a !== 32'h0 || ovf_a !== 1'b0 || mis_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_jump: pc=%h ovf=%b mis=%b, want pc=0 ovf=0 mis=0", pc_a, ovf_a, mis_a);
        end
        idle_a();
    endtask

    task automatic test_narrow();
        reset_b = 1'b1;
        cyc();
        checks++;
        if (pc_b !== 8'h10 || pc_seq_b !== 8'h12 || ovf_b !== 1'b0 || mis_b !== 1'b0) begin
            errors++;
            $display("FAIL narrow_reset: pc=%h seq=%h ovf=%b mis=%b, want pc=10 seq=12 ovf=0 mis=0", pc_b, pc_seq_b, ovf_b, mis_b);
        end
        reset_b = 1'b0; branch_b = 1'b1; offset_b = 8'hF7;
        cyc();
        checks++;
        if (pc_b !== 8'h00 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL narrow_branch_zero: pc=%h ovf=%b, want pc=0 ovf=0", pc_b, ovf_b);
        end
        branch_b = 1'b0; jump_b = 1'b1; jump_addr_b = 8'h41;
        cyc();
        checks++;
        if (pc_b !== 8'h00 || mis_b !== 1'b1) begin
            errors++;
            $display("FAIL narrow_misaligned: pc=%h mis=%b, want pc=0 mis=1", pc_b, mis_b);
        end
        jump_addr_b = 8'hFE;
        cyc();
        jump_b = 1'b0;
        cyc();
        checks++;
        if (pc_b !== 8'h00 || ovf_b !== 1'b1 || mis_b !== 1'b0) begin
            errors++;
            $display("FAIL narrow_wrap: pc=%h ovf=%b mis=%b, want pc=0 ovf=1 mis=0", pc_b, ovf_b, mis_b);
        end
        reset_b = 1'b1; jump_b = 1'b1; jump_addr_b = 8'h40;
        cyc();
        checks++;
        if (pc_b !== 8'h10 || ovf_b !== 1'b0 || mis_b !== 1'b0) begin
            errors++;
            $display("FAIL narrow_reset_over_jump: pc=%h ovf=%b mis=%b, want pc=10 ovf=0 mis=0", pc_b, ovf_b, mis_b);
        end
        reset_b = 1'b0; jump_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq_stall();
        test_branch();
        test_wrap();
        test_misaligned();
        test_branch_overflow();
        test_narrow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer: a registered PC that advances by a fixed step each cycle, with absolute jump, PC-relative branch and stall. It replaces the stand-alone combinational +4 incrementer in the fetch stage. Width, step and reset vector are generic. It flags address wrap-around and misaligned jump targets.

## Interface

Parameters:
- WIDTH, 32, address width in bits (≥ 8)
- STEP, 4, sequential increment in bytes; power of two, 1..2^(WIDTH-1)
- RESET_VECTOR, 0, PC value loaded on reset; must be STEP-aligned
- OFFSET_WIDTH, 16, width of the signed branch offset (≤ WIDTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and flags this cycle
- jump  in  1  load jump_addr as the next PC
- jump_addr  in  WIDTH  absolute jump target
- branch  in  1  take a PC-relative branch
- branch_offset  in  OFFSET_WIDTH  signed offset, in units of STEP
- pc  out  WIDTH  current PC (registered)
- pc_seq  out  WIDTH  pc + STEP mod 2^WIDTH (combinational from pc)
- overflow  out  1  sticky: an address computation wrapped
- misaligned  out  1  registered one-cycle pulse: rejected jump target

## Operation

- Next-PC priority, evaluated at each rising clk edge: reset > stall > jump > branch > sequential.
- reset: pc ← RESET_VECTOR, overflow ← 0, misaligned ← 0.
- stall: pc and overflow hold, misaligned ← 0. jump and branch are ignored, not queued.
- jump with jump_addr mod STEP = 0: pc ← jump_addr, overflow ← 0 (a new flow clears the sticky flag), misaligned ← 0.
- jump with jump_addr mod STEP ≠ 0: pc holds, overflow holds, misaligned ← 1. The jump is dropped, and branch is not taken in that cycle.
- branch (no jump): pc ← pc + STEP + sext(branch_offset)·STEP, computed in WIDTH+OFFSET_WIDTH+2 bits and then truncated to WIDTH.
  - If the exact value is < 0 or ≥ 2^WIDTH, overflow ← 1.
  - misaligned ← 0.
- Sequential (no control input asserted): pc ← pc_seq. If the carry out of pc + STEP is 1, overflow ← 1. misaligned ← 0.
- overflow stays at 1 until reset or an accepted jump. A wrap in the same cycle as a jump cannot happen, because jump has priority.
- pc is always STEP-aligned. Every update path preserves alignment.

## Timing

- Single clock domain. All state updates on the rising edge of clk.
- Latency from a control input to pc is one cycle. pc_seq follows pc combinationally, with no extra delay.
- Reset values: pc = RESET_VECTOR, overflow = 0, misaligned = 0. pc_seq = RESET_VECTOR + STEP.
- Reset is sampled like any other input. Asserting it mid-run overrides a same-cycle jump, branch or stall, and pc = RESET_VECTOR on the following cycle.
- Simultaneous jump and branch: jump wins and branch is discarded. Simultaneous stall and jump: stall wins.
- misaligned is high for exactly the cycle after a rejected jump. Back-to-back misaligned jumps keep it high continuously.
- No input is registered internally, so the upstream stage must hold jump or branch valid in the cycle it expects the update.

## Test plan

- Reset, then 3 free-running cycles (defaults) → pc = 0, 4, 8, 12. pc_seq = 16 when pc = 12. overflow = 0.
- Start at pc = 45·4 = 180 (via jump). One sequential cycle → pc = 184. Then stall for 2 cycles → pc stays 184.
- jump = 1, jump_addr = 0x100 → pc = 0x100. Next cycle branch = 1, branch_offset = -2 → pc = 0x100 + 4 − 8 = 0xFC, overflow = 0.
- jump to 0xFFFFFFF8, then 2 sequential cycles → pc = 0xFFFFFFFC, then 0x00000000, with overflow = 1 from the wrap cycle onward. A jump to 0x40 clears overflow to 0.
- jump_addr = 0x102 with pc = 0x40 → pc stays 0x40, misaligned = 1 for one cycle. Same cycle with branch = 1 → branch ignored.
- WIDTH = 8, STEP = 2, RESET_VECTOR = 0x10; branch_offset = -9 at pc = 0x10 → exact target 0x10 + 2 − 18 = 0 → pc = 0x00, overflow = 0. Then reset asserted in the same cycle as jump → pc = 0x10 and all flags 0.
